// File: rtl/jmp_pkg.sv
// Shared types for the jump-unit sequencer: branch kinds, FSM states and
// a helper that tells which kinds fetch two operand words.
package jmp_pkg;

    localparam int KIND_W = 2;

    typedef enum logic [KIND_W-1:0] {
        JMP_NEAR = 2'b00,
        JMP_FAR  = 2'b01,
        CALL_FAR = 2'b10,
        RET      = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_HI = 3'd1,
        FETCH_LO = 3'd2,
        RESOLVE  = 3'd3,
        POP      = 3'd4,
        DONE     = 3'd5
    } state_e;

    // Far jumps and calls carry a high operand word ahead of the low word.
    function automatic logic is_far(kind_e k);
        return (k == JMP_FAR) || (k == CALL_FAR);
    endfunction

endpackage

// File: rtl/jmp_ctrl_ret_stack.sv
// LIFO of return addresses. Pushes when full and pops when empty are
// dropped here; the caller decides how to flag them.
module ret_stack
    import jmp_pkg::*;
#(
    parameter int PC_W  = 23,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0] sp_q;
    logic [AW-1:0]   top_idx;

    assign full    = (sp_q == SP_W'(DEPTH));
    assign empty   = (sp_q == '0);
    assign top_idx = sp_q[AW-1:0] - AW'(1);
    assign dout    = mem_q[top_idx];

    // Only the pointer is reset; stale entries below it are never read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[AW-1:0]] <= din;
        end
    end

    push_pop_exclusive: assert property (@(posedge clk) disable iff (rst) !(push && pop));

endmodule

// File: rtl/jmp_ctrl.sv
// Branch sequencer: fetches the operand words, loads the jump unit, resolves
// the target and writes the PC back, with a return stack for CALL/RET.
module jmp_ctrl
    import jmp_pkg::*;
#(
    parameter int PC_W  = 23,
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      kind,
    input  logic [PC_W-1:0] pcin,
    output logic            busy,
    output logic            done,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            bus_en,
    output logic [DW-1:0]   bus_data,
    output logic            highbits_we,
    output logic            jmp_oe,
    input  logic            jmp_pcoe,
    input  logic [PC_W-1:0] jmp_pcout,
    output logic            pc_we,
    output logic [PC_W-1:0] pc_wdata,
    output logic            stack_ovf,
    output logic            stack_unf
);

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [PC_W-1:0] pcin_q, pcin_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic            st_push, st_pop, st_full, st_empty;
    logic [PC_W-1:0] st_dout;
    logic            far;
    logic [PC_W-1:0] fallthru;

    assign far      = is_far(kind_q);
    assign fallthru = pcin_q + (far ? PC_W'(2) : PC_W'(1));

    ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (st_push),
        .pop   (st_pop),
        .din   (fallthru),
        .dout  (st_dout),
        .full  (st_full),
        .empty (st_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            kind_q   <= JMP_NEAR;
            pcin_q   <= '0;
            target_q <= '0;
            lo_q     <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            pcin_q   <= pcin_d;
            target_q <= target_d;
            lo_q     <= lo_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        pcin_d      = pcin_q;
        target_d    = target_q;
        lo_d        = lo_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        st_push     = 1'b0;
        st_pop      = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        bus_en      = 1'b0;
        bus_data    = '0;
        highbits_we = 1'b0;
        jmp_oe      = 1'b0;
        pc_we       = 1'b0;
        pc_wdata    = '0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                // pcin is captured so the request address cannot move under us.
                if (start) begin
                    kind_d = kind_e'(kind);
                    pcin_d = pcin;
                    case (kind_e'(kind))
                        JMP_NEAR: state_d = FETCH_LO;
                        RET:      state_d = POP;
                        default:  state_d = FETCH_HI;
                    endcase
                end
            end
            FETCH_HI: begin
                mem_req  = 1'b1;
                mem_addr = pcin_q;
                if (mem_ack) begin
                    bus_en      = 1'b1;
                    bus_data    = mem_rdata;
                    highbits_we = 1'b1;
                    state_d     = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_req  = 1'b1;
                mem_addr = pcin_q + (far ? PC_W'(1) : PC_W'(0));
                if (mem_ack) begin
                    lo_d    = mem_rdata;
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                bus_en   = 1'b1;
                bus_data = lo_q;
                jmp_oe   = 1'b1;
                target_d = jmp_pcoe ? jmp_pcout : fallthru;
                // A CALL that overflows still jumps; only the return address is lost.
                if ((kind_q == CALL_FAR) && jmp_pcoe) begin
                    if (st_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        st_push = 1'b1;
                    end
                end
                state_d = DONE;
            end
            POP: begin
                if (st_empty) begin
                    target_d = pcin_q;
                    unf_d    = 1'b1;
                end else begin
                    target_d = st_dout;
                    st_pop   = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                pc_we    = 1'b1;
                pc_wdata = target_q;
                done     = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: tb/tb_jmp_ctrl.sv
// Directed bench for jmp_ctrl: a vector table of single branch operations,
// then hand-written sequences for stack overflow/LIFO and wait/reset corners.
module tb_jmp_ctrl;
    import jmp_pkg::*;

    localparam int PC_W = 23;
    localparam int DW   = 16;

    logic            clk, rst, start;
    logic [1:0]      kind;
    logic [PC_W-1:0] pcin;
    logic            busy, done, mem_req, mem_ack;
    logic [PC_W-1:0] mem_addr;
    logic [DW-1:0]   mem_rdata;
    logic            bus_en, highbits_we, jmp_oe, jmp_pcoe, pc_we;
    logic [DW-1:0]   bus_data;
    logic [PC_W-1:0] jmp_pcout, pc_wdata;
    logic            stack_ovf, stack_unf;

    jmp_ctrl #(.PC_W(PC_W), .DW(DW), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .kind(kind), .pcin(pcin),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_en(bus_en),
        .bus_data(bus_data), .highbits_we(highbits_we), .jmp_oe(jmp_oe),
        .jmp_pcoe(jmp_pcoe), .jmp_pcout(jmp_pcout), .pc_we(pc_we),
        .pc_wdata(pc_wdata), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // memory model state
    int              wait_cfg = 0;
    int              wcnt = 0;
    logic [DW-1:0]   word0, word1;
    logic [PC_W-1:0] base;

    // per-operation observations
    int              r_cyc, r_hb, r_nf;
    logic            r_ok;
    logic [PC_W-1:0] r_pc, r_a0, r_a1;
    logic [DW-1:0]   r_hbd, r_lo;

    typedef struct {
        logic [1:0]      kind;
        logic [PC_W-1:0] pcin;
        logic [DW-1:0]   w0, w1;
        logic            pcoe;
        logic [PC_W-1:0] pcout;
        int              wt;
        logic [PC_W-1:0] exp_pc;
        int              exp_cyc;
        int              exp_hb;
        logic [DW-1:0]   exp_hbd;
        int              exp_nf;
        logic [PC_W-1:0] exp_a0, exp_a1;
        logic [DW-1:0]   exp_lo;
        logic            exp_unf;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drop start, update the memory model at negedge, settle, sample.
    task automatic cycle();
        @(negedge clk);
        start = 1'b0;
        if (mem_req) begin
            if (wcnt == wait_cfg) begin
                mem_ack   = 1'b1;
                mem_rdata = (mem_addr == base) ? word0 : word1;
                wcnt      = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                wcnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            wcnt      = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic run_op(input logic [1:0] k, input logic [PC_W-1:0] pc,
                          input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic pcoe, input logic [PC_W-1:0] pcout, input int wt);
        kind = k; pcin = pc; base = pc; word0 = w0; word1 = w1;
        jmp_pcoe = pcoe; jmp_pcout = pcout; wait_cfg = wt;
        r_cyc = 1; r_hb = 0; r_nf = 0; r_ok = 1'b0;
        r_pc = '0; r_a0 = '0; r_a1 = '0; r_hbd = '0; r_lo = '0;
        start = 1'b1;
        for (int i = 0; i < 40 && !r_ok; i++) begin
            cycle();
            r_cyc++;
            if (highbits_we) begin
                r_hb++;
                r_hbd = bus_data;
            end
            if (mem_req && mem_ack) begin
                if (r_nf == 0) r_a0 = mem_addr;
                else r_a1 = mem_addr;
                r_nf++;
            end
            if (jmp_oe) r_lo = bus_data;
            if (pc_we) begin
                r_pc = pc_wdata;
                r_ok = 1'b1;
                check("done_with_pc_we", {31'd0, done}, 32'd1);
            end
        end
        check("op_complete", {31'd0, r_ok}, 32'd1);
        cycle();
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic pcwe_seen;
        rst = 1'b1; start = 1'b0; kind = 2'b00; pcin = '0;
        mem_ack = 1'b0; mem_rdata = '0; jmp_pcoe = 1'b0; jmp_pcout = '0;
        word0 = '0; word1 = '0; base = '0;

        //        kind   pcin       w0       w1       pcoe pcout       wt exp_pc     cyc hb hbd      nf a0         a1         lo       unf
        tbl[0] = '{2'b00, 23'h000100, 16'h0040, 16'h0000, 1'b1, 23'h000040, 0, 23'h000040, 4, 0, 16'h0000, 1, 23'h000100, 23'h000000, 16'h0040, 1'b0};
        tbl[1] = '{2'b01, 23'h7FFFFF, 16'h00AB, 16'h1234, 1'b0, 23'h555555, 0, 23'h000001, 5, 1, 16'h00AB, 2, 23'h7FFFFF, 23'h000000, 16'h1234, 1'b0};
        tbl[2] = '{2'b10, 23'h000200, 16'hBEEF, 16'h0123, 1'b1, 23'h012345, 0, 23'h012345, 5, 1, 16'hBEEF, 2, 23'h000200, 23'h000201, 16'h0123, 1'b0};
        tbl[3] = '{2'b11, 23'h000999, 16'h0000, 16'h0000, 1'b0, 23'h000000, 0, 23'h000202, 3, 0, 16'h0000, 0, 23'h000000, 23'h000000, 16'h0000, 1'b0};
        tbl[4] = '{2'b10, 23'h000400, 16'h0001, 16'h0002, 1'b0, 23'h070000, 0, 23'h000402, 5, 1, 16'h0001, 2, 23'h000400, 23'h000401, 16'h0002, 1'b0};
        tbl[5] = '{2'b11, 23'h000010, 16'h0000, 16'h0000, 1'b0, 23'h000000, 0, 23'h000010, 3, 0, 16'h0000, 0, 23'h000000, 23'h000000, 16'h0000, 1'b1};
        tbl[6] = '{2'b00, 23'h000300, 16'h7777, 16'h0000, 1'b0, 23'h000888, 2, 23'h000301, 6, 0, 16'h0000, 1, 23'h000300, 23'h000000, 16'h7777, 1'b1};

        do_reset();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
        check("rst_pc_we", {31'd0, pc_we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bus_en", {31'd0, bus_en}, 32'd0);
        check("rst_highbits_we", {31'd0, highbits_we}, 32'd0);
        check("rst_jmp_oe", {31'd0, jmp_oe}, 32'd0);
        check("rst_ovf", {31'd0, stack_ovf}, 32'd0);
        check("rst_unf", {31'd0, stack_unf}, 32'd0);

        for (int v = 0; v < 7; v++) begin
            run_op(tbl[v].kind, tbl[v].pcin, tbl[v].w0, tbl[v].w1, tbl[v].pcoe, tbl[v].pcout, tbl[v].wt);
            $display("vec %0d kind=%0d pcin=0x%06h -> pc=0x%06h cycles=%0d", v, tbl[v].kind, tbl[v].pcin, r_pc, r_cyc);
            check($sformatf("v%0d_pc", v), {9'd0, r_pc}, {9'd0, tbl[v].exp_pc});
            check($sformatf("v%0d_cycles", v), r_cyc, tbl[v].exp_cyc);
            check($sformatf("v%0d_hb_count", v), r_hb, tbl[v].exp_hb);
            check($sformatf("v%0d_fetches", v), r_nf, tbl[v].exp_nf);
            if (tbl[v].exp_hb > 0) check($sformatf("v%0d_hb_data", v), {16'd0, r_hbd}, {16'd0, tbl[v].exp_hbd});
            if (tbl[v].exp_nf > 0) begin
                check($sformatf("v%0d_addr0", v), {9'd0, r_a0}, {9'd0, tbl[v].exp_a0});
                check($sformatf("v%0d_lo_bus", v), {16'd0, r_lo}, {16'd0, tbl[v].exp_lo});
            end
            if (tbl[v].exp_nf > 1) check($sformatf("v%0d_addr1", v), {9'd0, r_a1}, {9'd0, tbl[v].exp_a1});
            check($sformatf("v%0d_ovf", v), {31'd0, stack_ovf}, 32'd0);
            check($sformatf("v%0d_unf", v), {31'd0, stack_unf}, {31'd0, tbl[v].exp_unf});
        end

        // Fill the stack, overflow it, then drain it in LIFO order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_op(2'b10, 23'h001000 + PC_W'(16 * i), 16'h0A00, 16'h0B00, 1'b1, 23'h020000 + PC_W'(i), 0);
            $display("call %0d pcin=0x%06h -> pc=0x%06h ovf=%0d", i, 23'h001000 + PC_W'(16 * i), r_pc, stack_ovf);
            check($sformatf("call%0d_pc", i), {9'd0, r_pc}, 32'h020000 + i);
        end
        check("ovf_after_8_calls", {31'd0, stack_ovf}, 32'd0);
        run_op(2'b10, 23'h005000, 16'h0A00, 16'h0B00, 1'b1, 23'h030000, 0);
        $display("call 8 pcin=0x005000 -> pc=0x%06h ovf=%0d", r_pc, stack_ovf);
        check("call8_pc_taken", {9'd0, r_pc}, 32'h030000);
        check("call8_ovf", {31'd0, stack_ovf}, 32'd1);
        for (int i = 7; i >= 0; i--) begin
            run_op(2'b11, 23'h000077, 16'h0, 16'h0, 1'b0, 23'h0, 0);
            $display("ret -> pc=0x%06h", r_pc);
            check($sformatf("ret%0d_pc", i), {9'd0, r_pc}, 32'h001000 + 16 * i + 2);
        end
        check("unf_after_drain", {31'd0, stack_unf}, 32'd0);
        run_op(2'b11, 23'h000077, 16'h0, 16'h0, 1'b0, 23'h0, 0);
        $display("ret on empty pcin=0x000077 -> pc=0x%06h unf=%0d", r_pc, stack_unf);
        check("ret_empty_pc", {9'd0, r_pc}, 32'h000077);
        check("ret_empty_unf", {31'd0, stack_unf}, 32'd1);
        check("ovf_still_sticky", {31'd0, stack_ovf}, 32'd1);

        // Slow memory, a stray start while busy, then reset inside FETCH_LO.
        do_reset();
        pcwe_seen = 1'b0;
        wait_cfg = 3; kind = 2'b01; pcin = 23'h003000; base = 23'h003000;
        word0 = 16'h1111; word1 = 16'h2222; jmp_pcoe = 1'b0;
        start = 1'b1;
        for (int n = 2; n <= 7; n++) begin
            cycle();
            if (pc_we) pcwe_seen = 1'b1;
            $display("slow cycle %0d mem_req=%0d addr=0x%06h hb=%0d", n, mem_req, mem_addr, highbits_we);
            check($sformatf("slow%0d_mem_req", n), {31'd0, mem_req}, 32'd1);
            check($sformatf("slow%0d_mem_addr", n), {9'd0, mem_addr}, (n <= 5) ? 32'h003000 : 32'h003001);
            check($sformatf("slow%0d_hb", n), {31'd0, highbits_we}, (n == 5) ? 32'd1 : 32'd0);
            if (n == 3) begin
                start = 1'b1;
                kind = 2'b11;
            end
        end
        rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        cycle();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycle();
            if (pc_we) pcwe_seen = 1'b1;
            check($sformatf("post_rst%0d_busy", n), {31'd0, busy}, 32'd0);
            check($sformatf("post_rst%0d_mem_req", n), {31'd0, mem_req}, 32'd0);
        end
        check("pc_we_never", {31'd0, pcwe_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
